// File: rtl/hdc_class_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hdc_class_pkg
// Description : Shared constants and the search FSM state type for the class
//               hypervector search path (query encoder, trainer, search).
// Revision    : 1.0 - initial release
// ============================================================================
package hdc_class_pkg;

    localparam int FRAME_W   = 64;
    localparam int N_FRAMES  = 3;
    localparam int N_CLASSES = 8;
    localparam int ID_W      = $clog2(N_CLASSES);
    localparam int IDX_W     = $clog2(N_FRAMES);
    localparam int DIST_W    = $clog2(FRAME_W * N_FRAMES + 1);
    localparam int POP_W     = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage : hdc_class_pkg
`default_nettype wire

// File: rtl/hvec_popcount.sv
`default_nettype none
// ============================================================================
// Module      : hvec_popcount
// Description : Purely combinational population count built as a recursive
//               binary adder tree. Each level splits the vector in half and
//               adds the two sub-counts, so depth grows as log2(FRAME_W).
// Revision    : 1.0 - initial release
// Ports       : vec_i  in   FRAME_W                 vector to count
//               cnt_o  out  $clog2(FRAME_W+1)       number of set bits
// ============================================================================
module hvec_popcount #(
    parameter  int FRAME_W = 64,
    localparam int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic [FRAME_W-1:0] vec_i,
    output logic [CNT_W-1:0]   cnt_o
);

    generate
        if (FRAME_W == 1) begin : g_leaf
            assign cnt_o = vec_i;
        end else begin : g_split
            localparam int LO_W  = FRAME_W / 2;
            localparam int HI_W  = FRAME_W - LO_W;
            localparam int LO_CW = $clog2(LO_W + 1);
            localparam int HI_CW = $clog2(HI_W + 1);

            logic [LO_CW-1:0] w_lo;
            logic [HI_CW-1:0] w_hi;

            hvec_popcount #(.FRAME_W(LO_W)) u_lo (
                .vec_i (vec_i[LO_W-1:0]),
                .cnt_o (w_lo)
            );

            hvec_popcount #(.FRAME_W(HI_W)) u_hi (
                .vec_i (vec_i[FRAME_W-1:LO_W]),
                .cnt_o (w_hi)
            );

            assign cnt_o = CNT_W'(w_lo) + CNT_W'(w_hi);
        end
    endgenerate

endmodule : hvec_popcount
`default_nettype wire

// File: rtl/class_hvec_search.sv
`default_nettype none
// ============================================================================
// Module      : class_hvec_search
// Description : Associative search over the class hypervector memory. Loads a
//               query as N_FRAMES frames, then sweeps every class frame by
//               frame, accumulating Hamming distance, and reports the nearest
//               class (lowest index wins ties) with its distance.
// Revision    : 1.0 - initial release
// Ports       : clk           in   1        rising-edge clock
//               rst           in   1        synchronous active-high reset
//               query_valid   in   1        query frame present
//               query_ready   out  1        query frame accepted (LOAD only)
//               query_frame   in   FRAME_W  query frame, in order 0..N_FRAMES-1
//               frame_id      out  ID_W     class select to class memory
//               frame_index   out  IDX_W    frame select to class memory
//               class_vec_in  in   FRAME_W  class memory frame (combinational)
//               result_valid  out  1        result available (DONE)
//               result_ready  in   1        consumer takes result
//               result_class  out  ID_W     nearest class index
//               result_dist   out  DIST_W   Hamming distance of nearest class
//               busy          out  1        high in SEARCH and DONE
// ============================================================================
module class_hvec_search
    import hdc_class_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               query_valid,
    output logic               query_ready,
    input  logic [FRAME_W-1:0] query_frame,
    output logic [ID_W-1:0]    frame_id,
    output logic [IDX_W-1:0]   frame_index,
    input  logic [FRAME_W-1:0] class_vec_in,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [ID_W-1:0]    result_class,
    output logic [DIST_W-1:0]  result_dist,
    output logic               busy
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_FRAMES - 1);
    localparam logic [ID_W-1:0]  c_LAST_ID  = ID_W'(N_CLASSES - 1);

    state_t              state_q,      state_d;
    logic [IDX_W-1:0]    load_cnt_q,   load_cnt_d;
    logic [ID_W-1:0]     frame_id_q,   frame_id_d;
    logic [IDX_W-1:0]    frame_index_q, frame_index_d;
    logic [DIST_W-1:0]   dist_acc_q,   dist_acc_d;
    logic [DIST_W-1:0]   best_dist_q,  best_dist_d;
    logic [ID_W-1:0]     best_class_q, best_class_d;
    logic [FRAME_W-1:0]  query_buf_q [N_FRAMES];

    logic                w_load_en;
    logic [FRAME_W-1:0]  w_xor;
    logic [POP_W-1:0]    w_frame_dist;
    logic [DIST_W-1:0]   w_total;

    // Distance of the currently selected query frame against the memory frame.
    assign w_xor   = query_buf_q[frame_index_q] ^ class_vec_in;
    assign w_total = dist_acc_q + DIST_W'(w_frame_dist);

    hvec_popcount #(.FRAME_W(FRAME_W)) u_popcount (
        .vec_i (w_xor),
        .cnt_o (w_frame_dist)
    );

    // Memory selects are registered; forced to zero while reset is held so
    // every output is quiet during reset.
    assign frame_id    = rst ? '0 : frame_id_q;
    assign frame_index = rst ? '0 : frame_index_q;

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        frame_id_d    = frame_id_q;
        frame_index_d = frame_index_q;
        dist_acc_d    = dist_acc_q;
        best_dist_d   = best_dist_q;
        best_class_d  = best_class_q;
        w_load_en     = 1'b0;
        query_ready   = 1'b0;
        result_valid  = 1'b0;
        result_class  = '0;
        result_dist   = '0;
        busy          = 1'b0;

        case (state_q)
            LOAD: begin
                query_ready = 1'b1;
                if (query_valid) begin
                    w_load_en = 1'b1;
                    if (load_cnt_q == c_LAST_IDX) begin
                        load_cnt_d    = '0;
                        frame_id_d    = '0;
                        frame_index_d = '0;
                        dist_acc_d    = '0;
                        best_dist_d   = '1;
                        state_d       = SEARCH;
                    end else begin
                        load_cnt_d = load_cnt_q + IDX_W'(1);
                    end
                end
            end

            SEARCH: begin
                busy = 1'b1;
                if (frame_index_q == c_LAST_IDX) begin
                    frame_index_d = '0;
                    dist_acc_d    = '0;
                    // Strict compare with ascending class order keeps the
                    // lowest index on a tie.
                    if (w_total < best_dist_q) begin
                        best_dist_d  = w_total;
                        best_class_d = frame_id_q;
                    end
                    if (frame_id_q == c_LAST_ID) begin
                        frame_id_d = '0;
                        state_d    = DONE;
                    end else begin
                        frame_id_d = frame_id_q + ID_W'(1);
                    end
                end else begin
                    frame_index_d = frame_index_q + IDX_W'(1);
                    dist_acc_d    = w_total;
                end
            end

            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                result_class = best_class_q;
                result_dist  = best_dist_q;
                if (result_ready) begin
                    state_d = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase

        if (rst) begin
            w_load_en    = 1'b0;
            query_ready  = 1'b0;
            result_valid = 1'b0;
            result_class = '0;
            result_dist  = '0;
            busy         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            load_cnt_q    <= '0;
            frame_id_q    <= '0;
            frame_index_q <= '0;
            dist_acc_q    <= '0;
            best_dist_q   <= '1;
            best_class_q  <= '0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            frame_id_q    <= frame_id_d;
            frame_index_q <= frame_index_d;
            dist_acc_q    <= dist_acc_d;
            best_dist_q   <= best_dist_d;
            best_class_q  <= best_class_d;
        end
    end

    // Query storage is pure datapath; only written on an accepted beat.
    always_ff @(posedge clk) begin
        if (w_load_en) begin
            query_buf_q[load_cnt_q] <= query_frame;
        end
    end

endmodule : class_hvec_search
`default_nettype wire

// File: tb/tb_class_hvec_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_class_hvec_search
// Description : Self-checking bench for class_hvec_search. A behavioural class
//               memory drives class_vec_in; expected results come from a
//               direct Hamming-distance search over the bench's own arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_class_hvec_search;
    import hdc_class_pkg::*;

    logic               clk;
    logic               rst;
    logic               query_valid;
    logic               query_ready;
    logic [FRAME_W-1:0] query_frame;
    logic [ID_W-1:0]    frame_id;
    logic [IDX_W-1:0]   frame_index;
    logic [FRAME_W-1:0] class_vec_in;
    logic               result_valid;
    logic               result_ready;
    logic [ID_W-1:0]    result_class;
    logic [DIST_W-1:0]  result_dist;
    logic               busy;

    logic [FRAME_W-1:0] rom [N_CLASSES][N_FRAMES];
    logic [FRAME_W-1:0] qv  [N_FRAMES];

    int n_assert = 0;
    int n_fail   = 0;
    int got_class;
    int got_dist;

    class_hvec_search dut (
        .clk          (clk),
        .rst          (rst),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .query_frame  (query_frame),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_dist  (result_dist),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural class memory: combinational read.
    always_comb begin
        class_vec_in = '0;
        if (int'(frame_index) < N_FRAMES) begin
            class_vec_in = rom[frame_id][frame_index];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Nearest class by exhaustive Hamming distance; first minimum wins.
    task automatic model(output int bc, output int bd);
        int d;
        bc = 0;
        bd = 1 << 30;
        for (int c = 0; c < N_CLASSES; c++) begin
            d = 0;
            for (int f = 0; f < N_FRAMES; f++) d += $countones(qv[f] ^ rom[c][f]);
            if (d < bd) begin
                bd = d;
                bc = c;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_query(input int gap_max);
        for (int f = 0; f < N_FRAMES; f++) begin
            repeat ($urandom_range(0, gap_max)) begin
                query_valid = 1'b0;
                query_frame = {$urandom, $urandom};
                step();
            end
            query_valid = 1'b1;
            query_frame = qv[f];
            step();
        end
        query_valid = 1'b0;
    endtask

    // Called right after the last accepted beat; waits for the result,
    // checks sweep/latency/result, optionally stalls, then hands shake.
    task automatic wait_result(input string tag, input int hold, input bit junk);
        int  bc, bd, edges;
        bit  sweep_ok, bp_ok;
        logic [ID_W-1:0]   c0;
        logic [DIST_W-1:0] d0;
        model(bc, bd);
        check({tag, "_busy_search"}, busy, 1);
        check({tag, "_qready_search"}, query_ready, 0);
        sweep_ok = 1'b1;
        edges    = 0;
        while (result_valid !== 1'b1 && edges < 100) begin
            if (int'(frame_id) != edges / N_FRAMES || int'(frame_index) != edges % N_FRAMES
                || int'(frame_index) >= N_FRAMES) sweep_ok = 1'b0;
            query_valid = 1'($urandom);
            query_frame = {$urandom, $urandom};
            step();
            edges++;
        end
        query_valid = 1'b0;
        check({tag, "_latency_edges"}, edges, N_CLASSES * N_FRAMES);
        check({tag, "_sweep_order"}, sweep_ok, 1);
        check({tag, "_class"}, result_class, bc);
        check({tag, "_dist"}, result_dist, bd);
        check({tag, "_sel_home"}, {frame_id, frame_index}, 0);
        got_class = int'(result_class);
        got_dist  = int'(result_dist);
        if (hold > 0) begin
            c0    = result_class;
            d0    = result_dist;
            bp_ok = 1'b1;
            repeat (hold) begin
                query_valid = 1'b1;
                query_frame = {$urandom, $urandom};
                step();
                if (result_valid !== 1'b1 || result_class !== c0 || result_dist !== d0
                    || query_ready !== 1'b0 || busy !== 1'b1) bp_ok = 1'b0;
            end
            query_valid = 1'b0;
            check({tag, "_backpressure_stable"}, bp_ok, 1);
        end
        result_ready = 1'b1;
        if (junk) begin
            query_valid = 1'b1;
            query_frame = {$urandom, $urandom};
        end
        step();
        result_ready = 1'b0;
        query_valid  = 1'b0;
        check({tag, "_qready_after_hs"}, query_ready, 1);
        check({tag, "_rv_drop"}, result_valid, 0);
    endtask

    task automatic stub_rom();
        for (int c = 0; c < N_CLASSES; c++)
            for (int f = 0; f < N_FRAMES; f++) rom[c][f] = (64'h1 << c) - 64'h1;
    endtask

    task automatic random_rom();
        for (int c = 0; c < N_CLASSES; c++)
            for (int f = 0; f < N_FRAMES; f++) rom[c][f] = {$urandom, $urandom};
    endtask

    initial begin
        int k, rv_seen, tc;
        logic [63:0] flips;
        rst          = 1'b1;
        query_valid  = 1'b0;
        query_frame  = '0;
        result_ready = 1'b0;
        stub_rom();
        for (int f = 0; f < N_FRAMES; f++) qv[f] = '0;

        repeat (2) step();
        check("reset_outputs_zero",
              {query_ready, result_valid, busy, frame_id, frame_index, result_class, result_dist}, 0);
        rst = 1'b0;
        #1;
        check("qready_after_reset", query_ready, 1);
        check("busy_after_reset", busy, 0);

        // Stub ROM, zero query -> class 0, distance 0.
        send_query(2);
        wait_result("zero", 0, 1'b0);
        check("zero_class_const", got_class, 0);
        check("zero_dist_const", got_dist, 0);

        // Stub ROM, all-ones query -> class 7, distance 3*(64-7).
        for (int f = 0; f < N_FRAMES; f++) qv[f] = '1;
        send_query(1);
        wait_result("ones", 0, 1'b1);
        check("ones_class_const", got_class, 7);
        check("ones_dist_const", got_dist, 171);

        // Tie between classes 3 and 5 -> lower index wins.
        for (int f = 0; f < N_FRAMES; f++) qv[f] = {$urandom, $urandom};
        for (int c = 0; c < N_CLASSES; c++)
            for (int f = 0; f < N_FRAMES; f++)
                rom[c][f] = (c == 3 || c == 5) ? qv[f] : ~qv[f];
        send_query(0);
        wait_result("tie", 0, 1'b0);
        check("tie_class_const", got_class, 3);
        check("tie_dist_const", got_dist, 0);

        // Random memory, query equal to class 2, with back-pressure.
        random_rom();
        for (int f = 0; f < N_FRAMES; f++) qv[f] = rom[2][f];
        send_query(3);
        wait_result("exact2", 10, 1'b1);
        check("exact2_class_const", got_class, 2);
        check("exact2_dist_const", got_dist, 0);

        // Random memory, noisy copies of random classes.
        for (int t = 0; t < 6; t++) begin
            random_rom();
            tc = $urandom_range(0, N_CLASSES - 1);
            for (int f = 0; f < N_FRAMES; f++) begin
                flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                qv[f] = rom[tc][f] ^ flips;
            end
            send_query(2);
            wait_result("noisy", (t % 2) * 3, t[0]);
        end

        // Reset in the middle of the sweep.
        random_rom();
        for (int f = 0; f < N_FRAMES; f++) qv[f] = {$urandom, $urandom};
        send_query(1);
        k = 0;
        while (int'(frame_id) != 4 && k < 50) begin
            step();
            k++;
        end
        check("reach_fid4", frame_id, 4);
        rst = 1'b1;
        #1;
        check("midrst_outputs_zero",
              {query_ready, result_valid, busy, frame_id, frame_index, result_class, result_dist}, 0);
        step();
        check("midrst_outputs_zero_post",
              {query_ready, result_valid, busy, frame_id, frame_index, result_class, result_dist}, 0);
        rst = 1'b0;
        #1;
        check("midrst_qready", query_ready, 1);
        rv_seen = 0;
        repeat (40) begin
            if (result_valid !== 1'b0 || busy !== 1'b0) rv_seen = 1;
            step();
        end
        check("midrst_no_result", rv_seen, 0);

        // Fresh query after the aborted one.
        for (int f = 0; f < N_FRAMES; f++) qv[f] = rom[6][f] ^ {32'h0, $urandom};
        send_query(2);
        wait_result("post_rst", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_class_hvec_search
`default_nettype wire
